formula_sum_sqrt_pipe_fsm: RTL
==============================

// Module: formula_sum_sqrt_pipe_fsm
//
// PURPOSE
//  Parametrised FSM + datapath computing res = sum_{i<N_ARGS} isqrt(arg[i]) with one external pipelined isqrt.
//  Instantiated beside a single isqrt (latency L, 1 result/cycle) in a top wrapper; drives x side, consumes y side.
//  Not pipelined itself; valid/ready on the argument side.
//  Back-to-back operation sets are accepted every N_ARGS+L+1 cycles.
//
// PARAMETERS
//  N_ARGS  3   number of arguments per operation, >=1
//  ARG_W   32  argument width, even; isqrt result width = ARG_W/2
//  RES_W   32  result width; must be >= ARG_W/2+$clog2(N_ARGS) (elab-time check); sum zero-extended
//
// PORTS
//  clk          in   1             clock, rising edge
//  rst_n        in   1             reset, asynchronous, active-low
//  arg_vld      in   1             argument set valid
//  arg_rdy      out  1             block can accept a set this cycle
//  args         in   N_ARGS*ARG_W  arg[i] = args[i*ARG_W +: ARG_W]
//  res_vld      out  1             one-cycle pulse, res valid
//  res          out  RES_W         sum of square roots
//  err          out  1             sticky protocol error (see CONFIGURATION)
//  isqrt_x_vld  out  1             issue to isqrt
//  isqrt_x      out  ARG_W         isqrt operand
//  isqrt_y_vld  in   1             isqrt result valid
//  isqrt_y      in   ARG_W/2       isqrt result
//
// BEHAVIOUR
//  Reset: state IDLE; arg_rdy=1; res_vld=0; res=0; err=0; isqrt_x_vld=0; isqrt_x=0; counters/accumulator 0.
//  States: IDLE, ISSUE, DRAIN, DONE. arg_rdy = (IDLE|DONE).
//  IDLE/DONE: arg_vld&arg_rdy -> capture args, acc<=0, issue_cnt<=0, rcv_cnt<=0, -> ISSUE; else DONE->IDLE.
//  ISSUE: isqrt_x_vld=1, isqrt_x=arg[issue_cnt]; issue_cnt++; at issue_cnt==N_ARGS-1 -> DRAIN.
//  ISSUE/DRAIN: each isqrt_y_vld adds zero-ext isqrt_y into acc, rcv_cnt++ (y may arrive during ISSUE when L<N_ARGS).
//  Last result (rcv_cnt==N_ARGS-1 & y_vld): res<=acc+y, -> DONE; res_vld=1 in DONE only; res holds until next DONE.
//  Timing: accept cycle 0; issues cycles 1..N_ARGS; last y cycle N_ARGS+L; res_vld cycle N_ARGS+L+1, new set may be
//   accepted that same cycle.
//  arg_vld while arg_rdy=0: ignored, no effect; args not sampled.
//  isqrt_y_vld in IDLE/DONE (e.g. in-flight results after reset): ignored, acc untouched.
//  Arithmetic: acc RES_W bits, unsigned, no wrap possible given RES_W rule.
//  Reset mid-operation: immediate return to reset values; no res_vld for the aborted set.
//  isqrt_x outputs registered; isqrt_x=0 whenever isqrt_x_vld=0.
//
// CONFIGURATION
//  FORMULA_SUM_PROTOCOL_CHECK_EN defined: err set (sticky until rst_n) on isqrt_y_vld in IDLE/DONE, or on
//   arg_vld rising while arg_rdy=0 and the set is later dropped (arg_vld deasserted before arg_rdy).
//  Not defined: err tied 0, no check logic synthesised; functional behaviour otherwise identical.
//
// STRUCTURE
//  Package formula_sum_pkg: state_e enum (IDLE,ISSUE,DRAIN,DONE), function res_w_min(n_args,arg_w).
//  Sub-module formula_sum_arg_sel: registered arg store + index mux (args, load, idx -> arg[idx]).
//  Top formula_sum_sqrt_pipe_fsm: FSM, counters, accumulator, optional checker.
//
// TESTING (bench uses isqrt model with configurable L; run L=1,4,16; N_ARGS=1,3,8)
//  N=3: args 16,25,36 -> res_vld once, res=15, exactly 3 isqrt_x_vld pulses in consecutive cycles.
//  N=3: all args 32'hFFFF_FFFF -> res=196605 (3*65535), no overflow.
//  Back-to-back: arg_vld held high, sets {4,9,16},{1,1,1} -> res 9 then 3, period N+L+1 cycles.
//  arg_vld pulsed while busy with {100,100,100} -> ignored; only first set's result produced.
//  rst_n low during DRAIN -> outputs at reset values asynchronously; stray y_vld afterwards -> no res_vld,
//   err=1 with FORMULA_SUM_PROTOCOL_CHECK_EN, err=0 without.
//  N=1, L=1: arg 0 -> res=0; arg 1 -> res=1; res_vld at cycle 3 after accept.

Source files
------------

// File: rtl/formula_sum_pkg.sv
// Shared state encoding and result-width helper for the sum-of-square-roots sequencer.
package formula_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Narrowest accumulator that cannot wrap when summing n_args roots of arg_w-bit operands.
  function automatic int res_w_min(input int n_args, input int arg_w);
    return arg_w / 2 + $clog2(n_args);
  endfunction

endpackage

// File: rtl/formula_sum_arg_sel.sv
// Holds one captured argument set and selects arg[idx]; store loads in one cycle, read is combinational.
// An idx beyond the last argument reads as zero.
module formula_sum_arg_sel
  import formula_sum_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int ARG_W  = 32,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [N_ARGS*ARG_W-1:0] args,
  input  logic [IDX_W-1:0]        idx,
  output logic [ARG_W-1:0]        arg
);

  logic [N_ARGS*ARG_W-1:0] store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store <= '0;
    end else if (load) begin
      store <= args;
    end
  end

  always_comb begin
    arg = '0;
    for (int i = 0; i < N_ARGS; i++) begin
      if (idx == IDX_W'(i)) begin
        arg = store[i*ARG_W +: ARG_W];
      end
    end
  end

endmodule

// File: rtl/formula_sum_sqrt_pipe_fsm.sv
// Sequences N_ARGS operands through one external pipelined isqrt and sums the roots; one set per N_ARGS+L+1 cycles.
// Optional sticky protocol checker on err when FORMULA_SUM_PROTOCOL_CHECK_EN is defined.
module formula_sum_sqrt_pipe_fsm
  import formula_sum_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int ARG_W  = 32,
  parameter int RES_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arg_vld,
  output logic                    arg_rdy,
  input  logic [N_ARGS*ARG_W-1:0] args,
  output logic                    res_vld,
  output logic [RES_W-1:0]        res,
  output logic                    err,
  output logic                    isqrt_x_vld,
  output logic [ARG_W-1:0]        isqrt_x,
  input  logic                    isqrt_y_vld,
  input  logic [ARG_W/2-1:0]      isqrt_y
);

  localparam int CNT_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int IDX_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ARGS - 1);

  if (RES_W < res_w_min(N_ARGS, ARG_W)) begin : g_res_w_check
    $error("formula_sum_sqrt_pipe_fsm: RES_W too narrow for N_ARGS square roots");
  end
  if ((ARG_W % 2) != 0) begin : g_arg_w_check
    $error("formula_sum_sqrt_pipe_fsm: ARG_W must be even");
  end

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   rcv_cnt;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   res_q;
  logic [RES_W-1:0]   y_ext;
  logic               accept;
  logic               y_take;
  logic               y_last;
  logic               issue_nxt;
  logic [ARG_W-1:0]   x_nxt;
  logic               x_vld_q;
  logic [ARG_W-1:0]   x_q;
  logic [IDX_W-1:0]   sel_idx;
  logic [ARG_W-1:0]   sel_arg;

  assign arg_rdy = (state == IDLE) || (state == DONE);
  assign accept  = arg_vld && arg_rdy;
  assign y_ext   = RES_W'(isqrt_y);
  assign y_take  = isqrt_y_vld && ((state == ISSUE) || (state == DRAIN));
  assign y_last  = y_take && (rcv_cnt == LAST);
  // Operand registers are loaded one cycle ahead, so they look at the next index.
  assign sel_idx = {1'b0, issue_cnt} + IDX_W'(1);

  formula_sum_arg_sel #(
    .N_ARGS (N_ARGS),
    .ARG_W  (ARG_W),
    .IDX_W  (IDX_W)
  ) u_arg_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .args  (args),
    .idx   (sel_idx),
    .arg   (sel_arg)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (y_last) state_nxt = DONE;
      DONE:    state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_nxt = (state_nxt == ISSUE);
    x_nxt     = '0;
    if (accept) begin
      x_nxt = args[ARG_W-1:0];
    end else if (issue_nxt) begin
      x_nxt = sel_arg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      acc       <= '0;
      res_q     <= '0;
      x_vld_q   <= 1'b0;
      x_q       <= '0;
    end else begin
      state   <= state_nxt;
      x_vld_q <= issue_nxt;
      x_q     <= x_nxt;
      if (accept) begin
        issue_cnt <= '0;
        rcv_cnt   <= '0;
        acc       <= '0;
      end else begin
        if (state == ISSUE) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (y_take) begin
          acc     <= acc + y_ext;
          rcv_cnt <= rcv_cnt + CNT_W'(1);
        end
      end
      if (y_last) begin
        res_q <= acc + y_ext;
      end
    end
  end

  assign res_vld     = (state == DONE);
  assign res         = res_q;
  assign isqrt_x_vld = x_vld_q;
  assign isqrt_x     = x_q;

`ifdef FORMULA_SUM_PROTOCOL_CHECK_EN
  logic vld_q;
  logic pend_q;
  logic err_q;

  // A set raised while busy must stay up until accepted; dropping it early is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= arg_vld;
      if (arg_rdy) begin
        pend_q <= 1'b0;
      end else if (arg_vld && !vld_q) begin
        pend_q <= 1'b1;
      end
      if ((isqrt_y_vld && arg_rdy) || (pend_q && !arg_vld && !arg_rdy)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
